// File: rtl/page_walker.sv
`default_nettype none
// ============================================================================
// Module   : page_walker
// Purpose  : Two-level Sv32-style page table walker. Accepts one walk at a
//            time, issues at most one PTE load at a time, decodes PTEs and
//            returns a one-cycle result pulse with fault/permission info.
// Ports    : clk, rst_n (async, active-low)
//            IN_rq / IN_rqID   - walk request and requester ID
//            IN_flush          - abort current walk
//            OUT_ldUOp         - PTE load request (addr, valid)
//            IN_ldStall        - load port refused OUT_ldUOp this cycle
//            IN_ldResUOp       - PTE load data return (data, valid)
//            OUT_res           - walk result (vpn, ppn, fault, rwx, ...)
// Config   : define PW_SUPERPAGE_EN to accept level-1 leaves as superpages;
//            otherwise any level-1 leaf faults and isSuperPage is tied 0.
// Revision : 1.0 - initial release
// ============================================================================

package page_walker_pkg;

  localparam logic [1:0] PRIV_USER       = 2'd0;
  localparam logic [1:0] PRIV_SUPERVISOR = 2'd1;
  localparam logic [1:0] PRIV_MACHINE    = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [21:0] rootPPN;
    logic [1:0]  priv;
    logic        supervUserMemory;
    logic        makeExecReadable;
    logic        valid;
  } PageWalkRq;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
  } PW_LD_UOp;

  typedef struct packed {
    logic [31:0] data;
    logic        valid;
  } PW_LD_RES_UOp;

  typedef struct packed {
    logic [19:0] vpn;
    logic [21:0] ppn;
    logic        pageFault;
    logic        isSuperPage;
    logic [2:0]  rwx;
    logic [1:0]  rqID;
    logic        valid;
    logic        busy;
  } PageWalkRes;

endpackage

module page_walker
  import page_walker_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  PageWalkRq    IN_rq,
  input  logic [1:0]   IN_rqID,
  input  logic         IN_flush,
  output PW_LD_UOp     OUT_ldUOp,
  input  logic         IN_ldStall,
  input  PW_LD_RES_UOp IN_ldResUOp,
  output PageWalkRes   OUT_res
);

`ifdef PW_SUPERPAGE_EN
  localparam logic SUPER_EN = 1'b1;
`else
  localparam logic SUPER_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISS1  = 3'd1,
    S_WAIT1 = 3'd2,
    S_ISS0  = 3'd3,
    S_WAIT0 = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] vpn_q;
  logic [21:0] root_q;
  logic [1:0]  priv_q;
  logic        sum_q, mxr_q;
  logic [1:0]  rqid_q;
  logic [21:0] nppn_q, nppn_d;
  logic [21:0] res_ppn_q, res_ppn_d;
  logic [2:0]  res_rwx_q, res_rwx_d;
  logic        res_fault_q, res_fault_d;
  logic        res_super_q, res_super_d;

  // PTE address is formed at 34 bits so that an out-of-range table address
  // can be detected instead of silently wrapping.
  logic [33:0] w_addr1, w_addr0, w_iss_addr;
  logic        w_is_iss, w_iss_ovf, w_ld_valid, w_ld_fire, w_accept;
  logic [31:0] w_pte;
  logic        w_v, w_r, w_w, w_x, w_u, w_a;
  logic        w_pte_bad, w_leaf, w_perm_fault, w_sp_fault;
  logic [2:0]  w_rwx;
  logic [12:0] w_unused_bits;

  assign w_addr1    = {root_q, 12'b0} + {22'b0, vpn_q[19:10], 2'b00};
  assign w_addr0    = {nppn_q, 12'b0} + {22'b0, vpn_q[9:0], 2'b00};
  assign w_is_iss   = (state_q == S_ISS1) || (state_q == S_ISS0);
  assign w_iss_addr = (state_q == S_ISS0) ? w_addr0 : w_addr1;
  assign w_iss_ovf  = |w_iss_addr[33:32];
  assign w_ld_valid = w_is_iss && !w_iss_ovf;
  assign w_ld_fire  = w_ld_valid && !IN_ldStall;
  assign w_accept   = (state_q == S_IDLE) && IN_rq.valid && !IN_flush;

  assign w_pte = IN_ldResUOp.data;
  assign w_v   = w_pte[0];
  assign w_r   = w_pte[1];
  assign w_w   = w_pte[2];
  assign w_x   = w_pte[3];
  assign w_u   = w_pte[4];
  assign w_a   = w_pte[6];

  assign w_pte_bad    = !w_v || (!w_r && w_w);
  assign w_leaf       = w_r || w_x;
  assign w_perm_fault = !w_a
                      || ((priv_q == PRIV_USER) && !w_u)
                      || ((priv_q == PRIV_SUPERVISOR) && w_u && !sum_q);
  // A level-1 leaf must be 4 MiB aligned when superpages are supported.
  assign w_sp_fault   = SUPER_EN ? (|w_pte[19:10]) : 1'b1;
  assign w_rwx        = {w_r | (w_x & mxr_q), w_w, w_x};

  // G, D and RSW bits and the page offset play no part in the walk.
  assign w_unused_bits = {IN_rq.addr[11:0], ^{w_pte[9:7], w_pte[5]}};

  always_comb begin
    state_d     = state_q;
    nppn_d      = nppn_q;
    res_ppn_d   = res_ppn_q;
    res_rwx_d   = res_rwx_q;
    res_fault_d = res_fault_q;
    res_super_d = res_super_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d     = S_ISS1;
          res_ppn_d   = '0;
          res_rwx_d   = '0;
          res_fault_d = 1'b0;
          res_super_d = 1'b0;
        end
      end
      S_ISS1, S_ISS0: begin
        if (IN_flush) begin
          // An accepted load must still have its response drained.
          state_d = w_ld_fire ? S_DRAIN : S_IDLE;
        end else if (w_iss_ovf) begin
          state_d     = S_DONE;
          res_fault_d = 1'b1;
        end else if (!IN_ldStall) begin
          state_d = (state_q == S_ISS1) ? S_WAIT1 : S_WAIT0;
        end
      end
      S_WAIT1, S_WAIT0: begin
        if (IN_ldResUOp.valid) begin
          if (IN_flush) begin
            state_d = S_IDLE;
          end else if (!w_pte_bad && !w_leaf && (state_q == S_WAIT1)) begin
            state_d = S_ISS0;
            nppn_d  = w_pte[31:10];
          end else begin
            state_d     = S_DONE;
            res_ppn_d   = w_pte[31:10];
            res_rwx_d   = w_rwx;
            res_super_d = 1'b0;
            if (w_pte_bad || !w_leaf) begin
              res_fault_d = 1'b1;
            end else if (state_q == S_WAIT1) begin
              res_fault_d = w_perm_fault || w_sp_fault;
              res_super_d = SUPER_EN && !(w_perm_fault || w_sp_fault);
            end else begin
              res_fault_d = w_perm_fault;
            end
          end
        end else if (IN_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (IN_ldResUOp.valid) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vpn_q       <= '0;
      root_q      <= '0;
      priv_q      <= '0;
      sum_q       <= 1'b0;
      mxr_q       <= 1'b0;
      rqid_q      <= '0;
      nppn_q      <= '0;
      res_ppn_q   <= '0;
      res_rwx_q   <= '0;
      res_fault_q <= 1'b0;
      res_super_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nppn_q      <= nppn_d;
      res_ppn_q   <= res_ppn_d;
      res_rwx_q   <= res_rwx_d;
      res_fault_q <= res_fault_d;
      res_super_q <= res_super_d;
      if (w_accept) begin
        vpn_q  <= IN_rq.addr[31:12];
        root_q <= IN_rq.rootPPN;
        priv_q <= IN_rq.priv;
        sum_q  <= IN_rq.supervUserMemory;
        mxr_q  <= IN_rq.makeExecReadable;
        rqid_q <= IN_rqID;
      end
    end
  end

  always_comb begin
    OUT_ldUOp.valid = w_ld_valid;
    OUT_ldUOp.addr  = w_ld_valid ? w_iss_addr[31:0] : 32'h0;

    OUT_res.vpn         = vpn_q;
    OUT_res.ppn         = res_ppn_q;
    OUT_res.pageFault   = res_fault_q;
    OUT_res.isSuperPage = res_super_q & SUPER_EN;
    OUT_res.rwx         = res_rwx_q;
    OUT_res.rqID        = rqid_q;
    // A flush in the DONE cycle suppresses the result pulse.
    OUT_res.valid       = (state_q == S_DONE) && !IN_flush;
    OUT_res.busy        = (state_q != S_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_page_walker.sv
`default_nettype none
// ============================================================================
// Module   : tb_page_walker
// Purpose  : Self-checking bench for page_walker. A table of complete walks
//            is replayed through a small in-bench load responder, followed by
//            hand-written flush, drain and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_page_walker;
  import page_walker_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  PageWalkRq    IN_rq;
  logic [1:0]   IN_rqID;
  logic         IN_flush;
  PW_LD_UOp     OUT_ldUOp;
  logic         IN_ldStall;
  PW_LD_RES_UOp IN_ldResUOp;
  PageWalkRes   OUT_res;

  int n_pass  = 0;
  int n_total = 0;

  page_walker u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IN_rq       (IN_rq),
    .IN_rqID     (IN_rqID),
    .IN_flush    (IN_flush),
    .OUT_ldUOp   (OUT_ldUOp),
    .IN_ldStall  (IN_ldStall),
    .IN_ldResUOp (IN_ldResUOp),
    .OUT_res     (OUT_res)
  );

  always #5 clk = ~clk;

`ifdef PW_SUPERPAGE_EN
  localparam logic SP_FAULT = 1'b0;
  localparam logic SP_SUPER = 1'b1;
`else
  localparam logic SP_FAULT = 1'b1;
  localparam logic SP_SUPER = 1'b0;
`endif

  typedef struct {
    logic [21:0] root;
    logic [31:0] addr;
    logic [1:0]  priv;
    logic        sum;
    logic        mxr;
    logic [1:0]  id;
    logic [31:0] pte1;
    logic [31:0] pte0;
    int          stall;
    int          e_loads;
    logic [31:0] e_la0;
    logic [31:0] e_la1;
    logic        e_fault;
    logic        e_super;
    logic [21:0] e_ppn;
    logic [2:0]  e_rwx;
    int          e_lat;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [21:0] root, logic [31:0] addr, logic [1:0] priv,
                              logic sum, logic mxr, logic [1:0] id,
                              logic [31:0] p1, logic [31:0] p0, int stall, int nl,
                              logic [31:0] a0, logic [31:0] a1, logic f, logic sp,
                              logic [21:0] ppn, logic [2:0] rwx, int lat);
    vec_t v;
    v.root = root; v.addr = addr; v.priv = priv; v.sum = sum; v.mxr = mxr;
    v.id = id; v.pte1 = p1; v.pte0 = p0; v.stall = stall; v.e_loads = nl;
    v.e_la0 = a0; v.e_la1 = a1; v.e_fault = f; v.e_super = sp;
    v.e_ppn = ppn; v.e_rwx = rwx; v.e_lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    IN_rq       = '0;
    IN_rqID     = '0;
    IN_flush    = 1'b0;
    IN_ldStall  = 1'b0;
    IN_ldResUOp = '0;
  endtask

  task automatic drive_rq(input logic [21:0] root, input logic [31:0] addr,
                          input logic [1:0] priv, input logic sum, input logic mxr,
                          input logic [1:0] id);
    IN_rq.addr             = addr;
    IN_rq.rootPPN          = root;
    IN_rq.priv             = priv;
    IN_rq.supervUserMemory = sum;
    IN_rq.makeExecReadable = mxr;
    IN_rq.valid            = 1'b1;
    IN_rqID                = id;
  endtask

  // Replays one walk; the responder returns PTE data the cycle after a load
  // is accepted (level-1 PTE for the first load, level-0 for the second).
  task automatic run_walk(input int idx, input vec_t v);
    int   loads;
    int   stall_left;
    logic pend;
    logic got;
    string tag;
    tag = $sformatf("v%0d", idx);
    loads = 0; stall_left = v.stall; pend = 1'b0; got = 1'b0;
    @(negedge clk);
    drive_rq(v.root, v.addr, v.priv, v.sum, v.mxr, v.id);
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      IN_rq.valid       = 1'b0;
      IN_ldResUOp.valid = pend;
      IN_ldResUOp.data  = pend ? ((loads == 1) ? v.pte1 : v.pte0) : 32'h0;
      pend = 1'b0;
      if (OUT_ldUOp.valid) begin
        chk({tag, "_ld_addr"}, OUT_ldUOp.addr, (loads == 0) ? v.e_la0 : v.e_la1);
        if (stall_left > 0) begin
          IN_ldStall = 1'b1;
          stall_left--;
        end else begin
          IN_ldStall = 1'b0;
          pend = 1'b1;
          loads++;
        end
      end else begin
        IN_ldStall = 1'b0;
      end
      if (OUT_res.valid) begin
        got = 1'b1;
        chk({tag, "_latency"}, cyc, v.e_lat);
        chk({tag, "_fault"}, OUT_res.pageFault, v.e_fault);
        chk({tag, "_super"}, OUT_res.isSuperPage, v.e_super);
        chk({tag, "_rqid"}, OUT_res.rqID, v.id);
        chk({tag, "_vpn"}, OUT_res.vpn, v.addr[31:12]);
        chk({tag, "_busy"}, OUT_res.busy, 1'b1);
        if (!v.e_fault) begin
          chk({tag, "_ppn"}, OUT_res.ppn, v.e_ppn);
          chk({tag, "_rwx"}, OUT_res.rwx, v.e_rwx);
        end
      end
    end
    if (!got) chk({tag, "_timeout_no_result"}, 1'b0, 1'b1);
    chk({tag, "_loads"}, loads, v.e_loads);
    @(negedge clk);
    idle_inputs();
    chk({tag, "_idle_after"}, {OUT_res.valid, OUT_res.busy, OUT_ldUOp.valid}, 3'b000);
  endtask

  localparam logic [31:0] AA = 32'h8040_3000;   // vpn1=0x201, vpn0=0x003
  localparam logic [31:0] AB = 32'h4000_1000;   // vpn1=0x100, vpn0=0x001

  initial begin
    vecs[0]  = mk(22'h100, AB, PRIV_SUPERVISOR, 0, 0, 2, 32'h0400_0001, 32'h2000_00CF, 0, 2,
                  32'h0010_0400, 32'h1000_0004, 0, 0, 22'h080000, 3'b111, 5);
    vecs[1]  = mk(22'h100, AB, PRIV_SUPERVISOR, 0, 0, 1, 32'h2000_00CB, 32'h0, 0, 1,
                  32'h0010_0400, 32'h0, SP_FAULT, SP_SUPER, 22'h080000, 3'b101, 3);
    vecs[2]  = mk(22'h100, AB, PRIV_SUPERVISOR, 0, 0, 0, 32'h0000_0007, 32'h0, 0, 1,
                  32'h0010_0400, 32'h0, 1, 0, 22'h0, 3'b0, 3);
    vecs[3]  = mk(22'h100, AB, PRIV_SUPERVISOR, 0, 0, 3, 32'h0000_008B, 32'h0, 0, 1,
                  32'h0010_0400, 32'h0, 1, 0, 22'h0, 3'b0, 3);
    vecs[4]  = mk(22'h200, AA, PRIV_USER, 0, 0, 3, 32'h0400_0001, 32'h2000_00CF, 0, 2,
                  32'h0020_0804, 32'h1000_000C, 1, 0, 22'h0, 3'b0, 5);
    vecs[5]  = mk(22'h200, AA, PRIV_USER, 0, 0, 1, 32'h0400_0001, 32'h2000_00DF, 0, 2,
                  32'h0020_0804, 32'h1000_000C, 0, 0, 22'h080000, 3'b111, 5);
    vecs[6]  = mk(22'h200, AA, PRIV_SUPERVISOR, 0, 0, 2, 32'h0400_0001, 32'h2000_00DF, 0, 2,
                  32'h0020_0804, 32'h1000_000C, 1, 0, 22'h0, 3'b0, 5);
    vecs[7]  = mk(22'h200, AA, PRIV_SUPERVISOR, 1, 0, 0, 32'h0400_0001, 32'h2000_00DF, 0, 2,
                  32'h0020_0804, 32'h1000_000C, 0, 0, 22'h080000, 3'b111, 5);
    vecs[8]  = mk(22'h200, AA, PRIV_SUPERVISOR, 0, 1, 1, 32'h0400_0001, 32'h2000_00C9, 0, 2,
                  32'h0020_0804, 32'h1000_000C, 0, 0, 22'h080000, 3'b101, 5);
    vecs[9]  = mk(22'h200, AA, PRIV_SUPERVISOR, 0, 0, 2, 32'h0400_0001, 32'h2000_00C9, 0, 2,
                  32'h0020_0804, 32'h1000_000C, 0, 0, 22'h080000, 3'b001, 5);
    vecs[10] = mk(22'h200, AA, PRIV_SUPERVISOR, 0, 0, 3, 32'h0400_0001, 32'h0400_0001, 0, 2,
                  32'h0020_0804, 32'h1000_000C, 1, 0, 22'h0, 3'b0, 5);
    vecs[11] = mk(22'h200, AA, PRIV_SUPERVISOR, 0, 0, 0, 32'h0400_0000, 32'h0, 0, 1,
                  32'h0020_0804, 32'h0, 1, 0, 22'h0, 3'b0, 3);
    vecs[12] = mk(22'h100, AB, PRIV_SUPERVISOR, 0, 0, 1, 32'h2000_04CB, 32'h0, 0, 1,
                  32'h0010_0400, 32'h0, 1, 0, 22'h0, 3'b0, 3);
    vecs[13] = mk(22'h3FFFFF, 32'hFFC0_0000, PRIV_SUPERVISOR, 0, 0, 2, 32'h0, 32'h0, 0, 0,
                  32'h0, 32'h0, 1, 0, 22'h0, 3'b0, 2);
    vecs[14] = mk(22'h100, AB, PRIV_SUPERVISOR, 0, 0, 2, 32'h0400_0001, 32'h2000_00CF, 4, 2,
                  32'h0010_0400, 32'h1000_0004, 0, 0, 22'h080000, 3'b111, 9);
    vecs[15] = mk(22'h200, AA, PRIV_MACHINE, 0, 0, 3, 32'h0400_0001, 32'h2000_00DF, 0, 2,
                  32'h0020_0804, 32'h1000_000C, 0, 0, 22'h080000, 3'b111, 5);

    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_res", OUT_res, '0);
    chk("reset_ld", OUT_ldUOp, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_walk(i, vecs[i]);

    // Flush while waiting on level 1, response 3 cycles later, new request in DRAIN.
    @(negedge clk); drive_rq(22'h100, AB, PRIV_SUPERVISOR, 0, 0, 1);
    @(negedge clk); IN_rq.valid = 1'b0;
    chk("fl_iss1_ld", OUT_ldUOp.valid, 1'b1);
    @(negedge clk); IN_flush = 1'b1;
    chk("fl_wait1_valid", OUT_res.valid, 1'b0);
    @(negedge clk); IN_flush = 1'b0; drive_rq(22'h200, AA, PRIV_SUPERVISOR, 0, 0, 2);
    chk("fl_drain1", {OUT_res.valid, OUT_res.busy, OUT_ldUOp.valid}, 3'b010);
    @(negedge clk); IN_rq.valid = 1'b0;
    chk("fl_drain2", {OUT_res.valid, OUT_res.busy, OUT_ldUOp.valid}, 3'b010);
    @(negedge clk); IN_ldResUOp.valid = 1'b1; IN_ldResUOp.data = 32'h0400_0001;
    chk("fl_drain3", {OUT_res.valid, OUT_res.busy, OUT_ldUOp.valid}, 3'b010);
    @(negedge clk); IN_ldResUOp = '0;
    chk("fl_after_drain", {OUT_res.valid, OUT_res.busy, OUT_ldUOp.valid}, 3'b000);
    @(negedge clk);
    chk("fl_rq_ignored", {OUT_res.valid, OUT_res.busy, OUT_ldUOp.valid}, 3'b000);

    // Flush in WAIT1 together with the response: straight to IDLE.
    drive_rq(22'h100, AB, PRIV_SUPERVISOR, 0, 0, 0);
    @(negedge clk); IN_rq.valid = 1'b0;
    @(negedge clk); IN_flush = 1'b1; IN_ldResUOp.valid = 1'b1; IN_ldResUOp.data = 32'h2000_00CB;
    @(negedge clk); idle_inputs();
    chk("flresp_idle", {OUT_res.valid, OUT_res.busy}, 2'b00);

    // Flush in ISS1 with a stalled load: IDLE, nothing to drain.
    drive_rq(22'h100, AB, PRIV_SUPERVISOR, 0, 0, 0);
    @(negedge clk); IN_rq.valid = 1'b0; IN_ldStall = 1'b1; IN_flush = 1'b1;
    @(negedge clk); idle_inputs();
    chk("fliss_stall_idle", {OUT_res.busy, OUT_ldUOp.valid}, 2'b00);

    // Flush in ISS1 as the load is accepted: must drain.
    drive_rq(22'h100, AB, PRIV_SUPERVISOR, 0, 0, 0);
    @(negedge clk); IN_rq.valid = 1'b0; IN_flush = 1'b1;
    @(negedge clk); IN_flush = 1'b0;
    chk("fliss_fire_drain", {OUT_res.busy, OUT_ldUOp.valid}, 2'b10);
    IN_ldResUOp.valid = 1'b1; IN_ldResUOp.data = 32'h0400_0001;
    @(negedge clk); idle_inputs();
    chk("fliss_fire_idle", {OUT_res.valid, OUT_res.busy}, 2'b00);

    // Reset asserted mid-WAIT0, then a late response after release.
    drive_rq(22'h100, AB, PRIV_SUPERVISOR, 0, 0, 3);
    @(negedge clk); IN_rq.valid = 1'b0;
    @(negedge clk); IN_ldResUOp.valid = 1'b1; IN_ldResUOp.data = 32'h0400_0001;
    @(negedge clk); IN_ldResUOp = '0;
    chk("rst_iss0_ld", OUT_ldUOp.addr, 32'h1000_0004);
    @(negedge clk);
    chk("rst_wait0_busy", {OUT_res.busy, OUT_ldUOp.valid}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_res", OUT_res, '0);
    chk("rst_async_ld", OUT_ldUOp, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); IN_ldResUOp.valid = 1'b1; IN_ldResUOp.data = 32'h2000_00CF;
    @(negedge clk); IN_ldResUOp = '0;
    chk("rst_late_resp1", {OUT_res.valid, OUT_res.busy, OUT_ldUOp.valid}, 3'b000);
    @(negedge clk);
    chk("rst_late_resp2", {OUT_res.valid, OUT_res.busy, OUT_ldUOp.valid}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
